load_store_unit: RTL and testbench

Load/store unit for the RV32I core, directly downstream of `alu` in the execute stage. It takes `o_alu_out` as the effective address plus `funct3` and rs2 data, and runs one memory bus transaction per load or store. For stores it steers bytes and builds write strobes; for loads it extracts and sign- or zero-extends the result. It checks alignment and bus timeout, and reports a single-cycle completion to the pipeline.

---
 rtl/load_store_unit_pkg.sv | 18 +
 rtl/load_store_unit_align.sv | 60 ++++++
 rtl/load_store_unit.sv | 151 +++++++++++++++
 tb/tb_load_store_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the RV32I load/store unit.
//   - funct3 access-type constants (B, H, W, BU, HU)
//   - FSM state type for the top-level sequencer
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_DONE   = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: purely combinational data path of the load/store unit.
// Ports:
//   addr_lo    in  2  : low address bits (byte lane)
//   funct3     in  3  : access type
//   we         in  1  : 1 = store, 0 = load
//   wdata      in  32 : store data (rs2)
//   rdata      in  32 : raw bus read data
//   lane_wdata out 32 : store data replicated across lanes
//   wstrb      out 4  : byte enables for the store
//   err        out 1  : misaligned or illegal access
//   load_data  out 32 : extracted and extended load result
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] lane_wdata,
  output logic [3:0]  wstrb,
  output logic        err,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    lane_wdata = wdata;
    wstrb      = 4'b0000;
    err        = 1'b0;
    load_data  = 32'h0;
    case (funct3)
      F3_B, F3_BU: begin
        lane_wdata = {4{wdata[7:0]}};
        wstrb      = 4'b0001 << addr_lo;
        err        = we && (funct3 == F3_BU);
        load_data  = (funct3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
      end
      F3_H, F3_HU: begin
        lane_wdata = {2{wdata[15:0]}};
        wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
        err        = addr_lo[0] || (we && (funct3 == F3_HU));
        load_data  = (funct3 == F3_H) ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
      end
      F3_W: begin
        wstrb     = 4'b1111;
        err       = (addr_lo != 2'b00);
        load_data = rdata;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one bus transaction per RV32I load or store.
// Ports:
//   i_clk, i_rst_n         : clock, asynchronous active-low reset
//   i_req_valid/we/funct3  : request from execute (accepted while o_ready)
//   i_addr, i_wdata        : effective address, store data
//   o_ready                : high in IDLE
//   o_done, o_err          : one-cycle completion pulse and its error qualifier
//   o_rdata                : load result, held until the next accept
//   o_mem_addr/wdata/wstrb : word address, replicated data, byte enables
//   o_mem_rd, o_mem_wr     : bus strobes
//   i_mem_ready, i_mem_rdata : bus completion and read data
// TIMEOUT_CYCLES: wait-state limit before abort with error (0 disables).
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  input  logic        i_req_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_rdata,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_rdata
);

  localparam int              CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TIMEOUT_CYCLES);
  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  lsu_state_e       state_q, state_d;
  logic [1:0]       addr_lo_q;
  logic [2:0]       funct3_q;
  logic             we_q;
  logic [CNT_W-1:0] cnt_q;

  logic        accept, timeout_hit, err_d;
  logic [1:0]  al_addr;
  logic [2:0]  al_funct3;
  logic        al_we, al_err;
  logic [31:0] al_wdata, al_load;
  logic [3:0]  al_wstrb;

  assign accept      = (state_q == LSU_IDLE) && o_ready && i_req_valid;
  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_MAX);

  // One aligner serves both directions: steering/checking looks at the live
  // request in IDLE, extraction looks at the captured request afterwards.
  assign al_addr   = (state_q == LSU_IDLE) ? i_addr[1:0] : addr_lo_q;
  assign al_funct3 = (state_q == LSU_IDLE) ? i_funct3    : funct3_q;
  assign al_we     = (state_q == LSU_IDLE) ? i_req_we    : we_q;

  lsu_align u_align (
    .addr_lo    (al_addr),
    .funct3     (al_funct3),
    .we         (al_we),
    .wdata      (i_wdata),
    .rdata      (i_mem_rdata),
    .lane_wdata (al_wdata),
    .wstrb      (al_wstrb),
    .err        (al_err),
    .load_data  (al_load)
  );

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (accept) begin
          state_d = al_err ? LSU_DONE : LSU_ACCESS;
          err_d   = al_err;
        end
      end
      LSU_ACCESS: begin
        // Ready on the limit cycle wins over the timeout.
        if (i_mem_ready) begin
          state_d = LSU_DONE;
        end else if (timeout_hit) begin
          state_d = LSU_DONE;
          err_d   = 1'b1;
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= LSU_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ready     <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_rdata     <= 32'h0;
      o_mem_addr  <= 32'h0;
      o_mem_wdata <= 32'h0;
      o_mem_wstrb <= 4'h0;
      o_mem_rd    <= 1'b0;
      o_mem_wr    <= 1'b0;
      addr_lo_q   <= 2'b00;
      funct3_q    <= 3'b000;
      we_q        <= 1'b0;
      cnt_q       <= '0;
    end else begin
      o_ready <= (state_d == LSU_IDLE);
      o_done  <= (state_d == LSU_DONE);
      o_err   <= err_d;
      if (accept) begin
        addr_lo_q   <= i_addr[1:0];
        funct3_q    <= i_funct3;
        we_q        <= i_req_we;
        o_mem_addr  <= {i_addr[31:2], 2'b00};
        o_mem_wdata <= al_wdata;
        o_mem_wstrb <= (i_req_we && !al_err) ? al_wstrb : 4'h0;
        o_mem_rd    <= !al_err && !i_req_we;
        o_mem_wr    <= !al_err && i_req_we;
        o_rdata     <= 32'h0;
        cnt_q       <= '0;
      end else if (state_q == LSU_ACCESS) begin
        if (i_mem_ready) begin
          o_mem_rd <= 1'b0;
          o_mem_wr <= 1'b0;
          o_rdata  <= we_q ? 32'h0 : al_load;
        end else if (timeout_hit) begin
          o_mem_rd <= 1'b0;
          o_mem_wr <= 1'b0;
        end else if (TIMEOUT_EN) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (TIMEOUT_CYCLES = 4).
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        ready, done, err;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rd, mem_wr, mem_ready;
  logic [31:0] mem_rdata;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_we    (req_we),
    .i_funct3    (funct3),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_ready     (ready),
    .o_done      (done),
    .o_err       (err),
    .o_rdata     (rdata),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_wstrb (mem_wstrb),
    .o_mem_rd    (mem_rd),
    .o_mem_wr    (mem_wr),
    .i_mem_ready (mem_ready),
    .i_mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Expected output state, updated by the driver just after each rising edge.
  bit          chk_en = 1'b0;
  logic        exp_ready, exp_done, exp_err, exp_rd, exp_wr;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;
  logic [3:0]  exp_wstrb;

  // Observations used by the literal pins.
  int          rd_cycles, wr_cycles, done_cyc, acc_cyc;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_wstrb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  // Compare process: every falling edge.
  always @(negedge clk) begin
    if (mem_rd) rd_cycles++;
    if (mem_wr) wr_cycles++;
    if (mem_rd || mem_wr) begin
      seen_addr  = mem_addr;
      seen_wdata = mem_wdata;
      seen_wstrb = mem_wstrb;
    end
    if (done) done_cyc = cyc;
    if (chk_en) begin
      check("ready", ready, exp_ready);
      check("done", done, exp_done);
      check("err", err, exp_err);
      check("mem_rd", mem_rd, exp_rd);
      check("mem_wr", mem_wr, exp_wr);
      check("rd_wr_excl", mem_rd & mem_wr, 0);
      if (exp_done || exp_ready) check("rdata", rdata, exp_rdata);
      if (exp_rd || exp_wr) check("mem_addr", mem_addr, exp_addr);
      if (exp_wr) begin
        check("mem_wdata", mem_wdata, exp_wdata);
        check("mem_wstrb", mem_wstrb, exp_wstrb);
      end
    end
  end

  // Behavioural model: byte-size / modulo arithmetic view of the access rules.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd,
                                output bit e, output logic [31:0] lanes,
                                output logic [3:0] strb, output logic [31:0] ld);
    int sz;
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    case (f3)
      3'd0:    sz = 1;
      3'd1:    sz = 2;
      3'd2:    sz = 4;
      3'd4:    sz = we ? 0 : 1;
      3'd5:    sz = we ? 0 : 2;
      default: sz = 0;
    endcase
    e     = (sz == 0) || ((a % sz) != 0);
    lanes = (sz == 1) ? wd[7:0] * 32'h01010101 : (sz == 2) ? wd[15:0] * 32'h00010001 : wd;
    strb  = (sz == 0) ? 4'h0 : 4'(((32'd1 << sz) - 1) << (a % 4));
    sh    = rd >> (8 * (a % 4));
    b     = sh[7:0];
    h     = sh[15:0];
    case (f3)
      3'd0:    ld = 32'($signed(b));
      3'd1:    ld = 32'($signed(h));
      3'd4:    ld = {24'h0, b};
      3'd5:    ld = {16'h0, h};
      default: ld = rd;
    endcase
    if (we) ld = 32'h0;
  endfunction

  task automatic set_idle();
    exp_ready = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
    exp_rd = 1'b0; exp_wr = 1'b0;
  endtask

  // One access; waits = cycles before ready (-1 = never ready).
  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input int waits);
    bit e;
    logic [31:0] lanes, ld;
    logic [3:0]  strb;
    int n;
    model(we, f3, a, wd, rd, e, lanes, strb, ld);
    n = 0;
    while (!ready && n < 20) begin tick(); n++; end
    if (!ready) check("ready_wait_timeout", ready, 1);
    rd_cycles = 0; wr_cycles = 0; done_cyc = -1;
    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
    acc_cyc = cyc;
    tick();
    req_valid = 1'b0;
    exp_ready = 1'b0;
    if (e) begin
      exp_done = 1'b1; exp_err = 1'b1; exp_rdata = 32'h0;
      tick();
    end else begin
      exp_rd = !we; exp_wr = we; exp_addr = {a[31:2], 2'b00};
      exp_wdata = lanes; exp_wstrb = strb; exp_done = 1'b0;
      for (int i = 0; i <= TO; i++) begin
        mem_ready = (i == waits);
        mem_rdata = (i == waits) ? rd : ~rd;
        tick();
        mem_ready = 1'b0;
        if (i == waits || i == TO) begin
          exp_rd = 1'b0; exp_wr = 1'b0; exp_done = 1'b1;
          exp_err   = (i != waits);
          exp_rdata = (i == waits) ? ld : 32'h0;
          break;
        end
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'd0;
    addr = 32'h0; wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    #12;
    check("rst_ready", ready, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_strobes", {mem_rd, mem_wr, mem_wstrb}, 0);
    check("rst_mem_addr", mem_addr, 0);
    @(negedge clk); #1 rst_n = 1'b1;
    check("ready_before_edge", ready, 0);
    tick();
    check("ready_after_edge", ready, 1);
    set_idle(); exp_rdata = 32'h0; chk_en = 1'b1;

    // SW zero-wait
    run(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 0);
    check("sw_lat", done_cyc - acc_cyc, 2);
    check("sw_addr", seen_addr, 32'h0000_0104);
    check("sw_wstrb", seen_wstrb, 4'b1111);
    check("sw_wr_cycles", wr_cycles, 1);
    // SB lane replication
    run(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0);
    check("sb_wdata", seen_wdata, 32'hA5A5_A5A5);
    check("sb_wstrb", seen_wstrb, 4'b1000);
    // LB vs LBU
    run(1'b0, 3'b000, 32'h0000_0102, 32'h0, 32'h12F4_5678, 0);
    check("lb_rdata", rdata, 32'hFFFF_FFF4);
    run(1'b0, 3'b100, 32'h0000_0102, 32'h0, 32'h12F4_5678, 0);
    check("lbu_rdata", rdata, 32'h0000_00F4);
    // LH with 3 wait states
    run(1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_0000, 3);
    check("lh_rdata", rdata, 32'hFFFF_8001);
    check("lh_lat", done_cyc - acc_cyc, 5);
    // Misaligned LW, store with HU funct3
    run(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 0);
    check("lw_mis_lat", done_cyc - acc_cyc, 1);
    check("lw_mis_rd_cycles", rd_cycles, 0);
    run(1'b1, 3'b101, 32'h0000_0100, 32'h1234_5678, 32'h0, 0);
    check("sh_f3_101_lat", done_cyc - acc_cyc, 1);
    check("sh_f3_101_wr_cycles", wr_cycles, 0);
    // Timeout, then ready exactly at the limit
    run(1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h5555_AAAA, -1);
    check("to_rd_cycles", rd_cycles, TO + 1);
    check("to_lat", done_cyc - acc_cyc, TO + 2);
    run(1'b0, 3'b101, 32'h0000_0106, 32'h0, 32'h9ABC_1234, TO);
    check("lhu_limit_rdata", rdata, 32'h0000_9ABC);
    // More patterns
    run(1'b1, 3'b001, 32'h0000_010A, 32'h1234_ABCD, 32'h0, 1);
    check("sh_wdata", seen_wdata, 32'hABCD_ABCD);
    check("sh_wstrb", seen_wstrb, 4'b1100);
    run(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 0);
    run(1'b0, 3'b010, 32'h0000_010C, 32'h0, 32'h1122_3344, 1);
    check("lw_rdata", rdata, 32'h1122_3344);

    // Reset during ACCESS
    chk_en = 1'b0;
    done_cyc = -1;
    req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h0000_0300;
    tick();
    req_valid = 1'b0;
    tick();
    check("pre_rst_rd", mem_rd, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_rd", mem_rd, 0);
    check("rst_mid_ready", ready, 0);
    tick(); tick();
    @(negedge clk); #1 rst_n = 1'b1;
    check("rst_mid_ready_low", ready, 0);
    tick();
    check("rst_mid_ready_back", ready, 1);
    tick(); tick();
    check("rst_mid_no_done", done_cyc, -1);
    set_idle(); exp_rdata = 32'h0; chk_en = 1'b1;
    run(1'b1, 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 32'h0, 0);
    check("post_rst_sw_lat", done_cyc - acc_cyc, 2);

    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
